// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier.
// Retires one overlapping multiplier triplet per RUN cycle. It accumulates
// shifted multiples of the sign-extended multiplicand into a 2*WIDTH product.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   a, b                signed multiplicand / multiplier (WIDTH bits)
//   out_valid/out_ready product handshake; DONE holds under back-pressure
//   product             signed a*b (2*WIDTH bits); it is held until the next DONE
//   busy                high while iterating (RUN)
//   triplet             Booth triplet {b[2i+1], b[2i], b[2i-1]} in RUN, else 0
module booth_radix4_seq_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH/2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [2:0]           triplet
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned BW = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     a_reg, a_nxt;
    logic [BW-1:0]     bx, bx_nxt;
    logic [PW-1:0]     acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PW-1:0]     product_nxt;
    logic [PW-1:0]     mult;
    logic [PW-1:0]     pp;

    // Booth digit selection for the current triplet, weighted by 4^cnt
    always_comb begin
        mult = '0;
        case (bx[2:0])
            3'b001, 3'b010: mult = a_reg;
            3'b011:         mult = a_reg << 1;
            3'b100:         mult = -(a_reg << 1);
            3'b101, 3'b110: mult = -a_reg;
            default:        mult = '0;
        endcase
        pp = mult << {cnt, 1'b0};
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt   = state;
        a_nxt       = a_reg;
        bx_nxt      = bx;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        product_nxt = product;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = {{WIDTH{a[WIDTH-1]}}, a};
                    bx_nxt    = {b, 1'b0};
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                acc_nxt = acc + pp;
                bx_nxt  = BW'($signed(bx) >>> 2);
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    product_nxt = acc + pp;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            bx        <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            triplet   <= 3'b000;
        end else begin
            state     <= state_nxt;
            a_reg     <= a_nxt;
            bx        <= bx_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            product   <= product_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
            triplet   <= (state_nxt == RUN) ? bx_nxt[2:0] : 3'b000;
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
module tb_booth_radix4_seq_mult;

    localparam int unsigned W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
    logic             busy;
    logic [2:0]       triplet;

    int checks = 0;
    int errors = 0;

    booth_radix4_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .triplet   (triplet)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE and drop in_valid after the accepting edge
    task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_start", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = aa;
        b        = bb;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_back_idle"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [2*W-1:0] exp);
        int lat;
        start_op(aa, bb);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_product"}, 32'(product), 32'(exp));
        finish_op(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2*W-1:0] held;
        logic signed [2*W-1:0] sa, sb;
        logic [W-1:0] ra, rb;
        int lat;

        vecs[0]  = '{8'h03, 8'h05, 16'h000F};   // 3*5
        vecs[1]  = '{8'h80, 8'h80, 16'h4000};   // -128*-128
        vecs[2]  = '{8'h7F, 8'h80, 16'hC080};   // 127*-128
        vecs[3]  = '{8'h00, 8'hFF, 16'h0000};   // 0*-1
        vecs[4]  = '{8'hFF, 8'hFF, 16'h0001};   // -1*-1
        vecs[5]  = '{8'hF9, 8'h09, 16'hFFC1};   // -7*9
        vecs[6]  = '{8'h7F, 8'h7F, 16'h3F01};   // 127*127
        vecs[7]  = '{8'h80, 8'h7F, 16'hC080};   // -128*127
        vecs[8]  = '{8'h01, 8'h80, 16'hFF80};   // 1*-128
        vecs[9]  = '{8'hFF, 8'h01, 16'hFFFF};   // -1*1
        vecs[10] = '{8'h64, 8'hFD, 16'hFED4};   // 100*-3
        vecs[11] = '{8'hB3, 8'hC9, 16'h108B};   // -77*-55

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_product",   32'(product),   32'd0);
        check("reset_triplet",   32'(triplet),   32'd0);

        // Triplet sequence and busy for 3*5
        start_op(8'h03, 8'h05);
        check("t1_busy",     32'(busy),     32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_trip0",    32'(triplet),  32'd2);
        tick();
        check("t1_trip1",    32'(triplet),  32'd2);
        tick();
        check("t1_trip2",    32'(triplet),  32'd0);
        tick();
        check("t1_trip3",    32'(triplet),  32'd0);
        check("t1_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid",    32'(out_valid), 32'd1);
        check("t1_product",  32'(product),   32'd15);
        check("t1_busy_off", 32'(busy),      32'd0);
        check("t1_trip_off", 32'(triplet),   32'd0);
        finish_op("t1");

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-pressure: DONE holds for 10 cycles
        start_op(8'h7F, 8'h80);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'd4);
        held = product;
        check("bp_product", 32'(held), 32'h0000C080);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i),    32'(out_valid), 32'd1);
            check($sformatf("bp_stable_%0d", i),   32'(product),   32'(held));
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready),  32'd0);
        end
        finish_op("bp");
        check("bp_product_kept", 32'(product), 32'h0000C080);

        // in_valid held with new operands during RUN and across DONE exit
        in_valid = 1'b1;
        a        = 8'h03;
        b        = 8'h05;
        tick();
        a = 8'h0A;
        b = 8'h0A;
        wait_done(lat);
        check("hold_latency", 32'(lat), 32'd4);
        check("hold_first",   32'(product), 32'd15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_idle",      32'(in_ready), 32'd1);
        check("hold_not_busy",  32'(busy),     32'd0);
        tick();
        in_valid = 1'b0;
        check("hold_second_taken", 32'(busy), 32'd1);
        wait_done(lat);
        check("hold_latency2",  32'(lat), 32'd4);
        check("hold_second",    32'(product), 32'd100);
        finish_op("hold");

        // Reset in RUN cycle 2 discards the operation
        start_op(8'h32, 8'h32);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy",      32'(busy),      32'd0);
        check("mrst_product",   32'(product),   32'd0);
        check("mrst_triplet",   32'(triplet),   32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mrst_quiet_%0d", i), 32'(out_valid), 32'd0);
        end
        run_op("mrst_after", 8'hF9, 8'h09, 16'hFFC1);

        // Random sweep against a signed reference
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            sa = {{W{ra[W-1]}}, ra};
            sb = {{W{rb[W-1]}}, rb};
            run_op($sformatf("rnd%0d", i), ra, rb, 16'(sa * sb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
